// File: rtl/button_reader_pkg.sv
// Shared types and default timing for the push-button reader.
// Defaults assume a 27 MHz system clock.
package button_reader_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 270000;    // 10 ms
    localparam int DEFAULT_LONG_CYCLES     = 27000000;  // 1 s
    localparam int DEFAULT_REPEAT_CYCLES   = 5400000;   // 200 ms

    localparam int COUNT_W = 6;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the asynchronous button input.
// Resets to 1 so a reset always looks like a released (active-low) button.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level
);

    logic meta;

    // NOTE: non-blocking assignments make the two flops a real shift chain;
    // blocking here would collapse them into a single stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= 1'b1;
            level <= 1'b1;
        end else begin
            meta  <= btn_n;
            level <= meta;
        end
    end

endmodule

// File: rtl/button_reader.sv
// Debounced push-button reader: press/release/long-press strobes and a press counter.
// Define BUTTON_READER_AUTOREPEAT_EN to repeat press_pulse every REPEAT_CYCLES after a long press.
module button_reader
    import button_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_n,
    output logic               pressed,
    output logic               press_pulse,
    output logic               release_pulse,
    output logic               long_pulse,
    output logic [COUNT_W-1:0] count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    // The debounce window includes the cycle that left IDLE/HELD, hence the -2.
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_reader: DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("button_reader: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("button_reader: REPEAT_CYCLES must be at least 2");
    end

    logic              sync_level;
    logic              raw;
    state_t            state;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;

`ifdef BUTTON_READER_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_cnt;
`else
    // Without auto-repeat no repeat counter exists; press_pulse fires once per accepted press.
`endif

    btn_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_n),
        .level (sync_level)
    );

    assign raw = ~sync_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            count         <= '0;
`ifdef BUTTON_READER_AUTOREPEAT_EN
            rep_cnt       <= '0;
`endif
        end else begin
            // NOTE: strobes default low every cycle so each one lasts exactly one clock.
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (raw) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= '0;
                    end
                end

                PRESS_WAIT: begin
                    if (!raw) begin
                        state <= IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= HELD;
                        press_pulse <= 1'b1;
                        pressed     <= 1'b1;
                        count       <= count + 6'd1;
                        hold_cnt    <= '0;
`ifdef BUTTON_READER_AUTOREPEAT_EN
                        rep_cnt     <= '0;
`endif
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end

                HELD: begin
                    if (!raw) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= '0;
                    end else begin
                        // Saturating at HOLD_MAX guarantees one long_pulse per press.
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt   <= HOLD_MAX;
                            long_pulse <= 1'b1;
                        end else if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
`ifdef BUTTON_READER_AUTOREPEAT_EN
                        if (hold_cnt == HOLD_MAX) begin
                            if (rep_cnt == REP_LAST) begin
                                rep_cnt     <= '0;
                                press_pulse <= 1'b1;
                                count       <= count + 6'd1;
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
                        end
`endif
                    end
                end

                RELEASE_WAIT: begin
                    if (raw) begin
                        state <= HELD;
                    end else if (db_cnt == DB_LAST) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        pressed       <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/button_reader.md
BUTTON_READER -- requirements
Module: button_reader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 270000, meaning cycles the input must be stable to accept a change (10 ms at 27 MHz).
REQ-002 SHALL have parameter LONG_CYCLES, default 27000000, meaning cycles held after debounce before a long-press event (1 s).
REQ-003 SHALL have parameter REPEAT_CYCLES, default 5400000, meaning the auto-repeat period (200 ms), used only when the feature is compiled in.
REQ-004 SHALL have port clk  input  1  system clock; one clock, with all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port btn_n  input  1  raw push-button, active-low, asynchronous to clk.
REQ-007 SHALL have port pressed  output  1  debounced button level, 1 = held.
REQ-008 SHALL have port press_pulse  output  1  one-cycle strobe on an accepted press.
REQ-009 SHALL have port release_pulse  output  1  one-cycle strobe on an accepted release.
REQ-010 SHALL have port long_pulse  output  1  one-cycle strobe when the hold reaches LONG_CYCLES.
REQ-011 SHALL have port count  output  6  accepted-press counter for LED display.

Function
REQ-012 SHALL pass btn_n through a 2-flop synchronizer and invert it to form raw (1 = pressed); the synchronizer adds 2 cycles of latency.
REQ-013 SHALL implement FSM states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-014 SHALL, in IDLE with raw=1, move to PRESS_WAIT and clear the debounce counter.
REQ-015 SHALL, in PRESS_WAIT with raw=0, return to IDLE with no output event (glitch rejected).
REQ-016 SHALL, in PRESS_WAIT after raw has been 1 for DEBOUNCE_CYCLES consecutive cycles, enter HELD, assert press_pulse for one cycle, set pressed=1, increment count and clear the hold counter.
REQ-017 SHALL, in HELD, increment the hold counter, saturating at LONG_CYCLES, and assert long_pulse for exactly one cycle when the counter reaches LONG_CYCLES-1; long_pulse SHALL be emitted at most once per press.
REQ-018 SHALL, in HELD with raw=0, move to RELEASE_WAIT and clear the debounce counter.
REQ-019 SHALL, in RELEASE_WAIT with raw=1, return to HELD with no pulse and the hold counter preserved.
REQ-020 SHALL, in RELEASE_WAIT after raw has been 0 for DEBOUNCE_CYCLES consecutive cycles, enter IDLE, assert release_pulse for one cycle and set pressed=0.
REQ-021 SHALL wrap count from 63 to 0 modulo 64, with no saturation.
REQ-022 SHALL size the counter widths with $clog2 of the largest relevant parameter; DEBOUNCE_CYCLES≥2 and LONG_CYCLES>DEBOUNCE_CYCLES SHALL be checked at elaboration.
REQ-023 SHALL drive all pulse outputs directly from registers (no combinational paths from btn_n).

Reset
REQ-024 SHALL, on rst=1, return to IDLE, set the synchronizer flops to 1 (released), and clear pressed, all pulses, count and the internal counters on the next edge.
REQ-025 SHALL give rst priority mid-press with no release_pulse emitted, and SHALL require a fresh full debounce period after rst deasserts.

Configuration
REQ-026 SHALL, with BUTTON_READER_AUTOREPEAT_EN defined, after long_pulse in HELD re-assert press_pulse and increment count every REPEAT_CYCLES until leaving HELD.
REQ-027 SHALL, without BUTTON_READER_AUTOREPEAT_EN, exclude the repeat counter and repeat logic from the build, with press_pulse occurring only per REQ-016.

Structure
REQ-028 SHALL place the state enum and the default timing constants in package button_reader_pkg.
REQ-029 SHALL implement the synchronizer as sub-module btn_sync (2 flops, reset value 1).

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5)
REQ-030 SHALL cover: btn_n low for 3 cycles, then high -> no pulses, count=0.
REQ-031 SHALL cover: btn_n low for 10 cycles, then high for 10 cycles -> press_pulse 6 cycles after the falling edge, count=1, pressed held, and one release_pulse after release.
REQ-032 SHALL cover: a held press with a 2-cycle bounce high at hold cycle 8 -> a single press_pulse and no release_pulse.
REQ-033 SHALL cover: btn_n held for 40 cycles -> exactly one long_pulse 20 cycles after press_pulse; with the macro defined, 3 further press_pulses 5 cycles apart, count=4.
REQ-034 SHALL cover: 64 clean presses -> count wraps to 0.
REQ-035 SHALL cover: rst asserted during HELD -> all outputs 0 next cycle and no release_pulse.
